pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. It holds the program counter, drives the instruction-memory address and captures fetched instructions into the IF/ID pipeline register. It handles the branch redirect, pipeline stall, memory-ready handshake and a post-reset boot delay. The registered PC and IF/ID PC feed the downstream PC/branch-target adders.

Parameters:
PC_W, 8, PC and address width in bits
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, sequential PC increment; must be a power of two
BOOT_CYCLES, 2, cycles after reset before fetching begins (0 allowed)
NOP_INSTR, 32'h00000013, bubble encoding written to IF/ID

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard-unit stall; hold PC and IF/ID
branch_taken  in  1  redirect request from EX
branch_target  in  PC_W  redirect address
imem_ready  in  1  instruction memory has valid data this cycle
imem_data  in  INSTR_W  instruction read at imem_addr (combinational memory)
imem_addr  out  PC_W  equals pc register
imem_req  out  1  high when FSM is in RUN
pc  out  PC_W  current fetch PC
if_id_pc  out  PC_W  PC of the instruction held in IF/ID
if_id_instr  out  INSTR_W  instruction held in IF/ID
if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- Reset, sampled at an edge with rst=1:
  - pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - Boot counter loaded with BOOT_CYCLES.
  - State=BOOT, or RUN directly if BOOT_CYCLES=0.
  - rst overrides every other input, including mid-stall or mid-branch.
- FSM state BOOT:
  - imem_req=0; pc holds RESET_PC; IF/ID loads a bubble.
  - stall and branch_taken are ignored.
  - Counter decrements each cycle; on the cycle it reaches 1 → RUN.
- FSM state RUN: terminal until reset. Per-cycle priority, highest first:
  1. branch_taken=1: pc <= branch_target with the low log2(PC_STEP) bits cleared; IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc=0). Overrides stall and imem_ready.
  2. stall=1: pc and all IF/ID fields hold.
  3. imem_ready=0: pc holds; IF/ID <= bubble.
  4. Otherwise (fetch): IF/ID <= {pc, imem_data, valid=1}; pc <= pc + PC_STEP.
- Arithmetic: pc + PC_STEP is computed modulo 2^PC_W and wraps silently (8'hFC + 4 = 8'h00).
- Latency: an instruction at address X appears in IF/ID one cycle after the fetch cycle in which pc=X.
- Branch penalty: one bubble from this stage.
- imem_addr and pc are pure register outputs, with no combinational path from any input.

Optional Feature:
Macro PERF_COUNTERS_EN.
- Defined: adds outputs perf_fetch_cnt [15:0] and perf_bubble_cnt [15:0].
  - perf_fetch_cnt increments on each fetch cycle (rule 4).
  - perf_bubble_cnt increments on each cycle IF/ID loads a bubble in RUN (rules 1 and 3).
  - Both saturate at 16'hFFFF and clear on rst.
  - Stall-hold cycles are not counted.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with BOOT_CYCLES=2, imem_ready=1, no stall: if_id_valid=0 for 2 cycles after reset release. Fetch starts with pc=8'h00, then 04, 08; IF/ID shows pc 00 with the matching imem_data one cycle later.
- Sequential wrap: force pc to 8'hF8 by branching to 8'hF8. Subsequent pc sequence is FC, 00, 04; if_id_pc follows one cycle behind.
- Branch during stall: at pc=8'h10, assert stall=1 and branch_taken=1 with target 8'h43. Next pc=8'h40; IF/ID is a bubble (valid=0, instr=00000013).
- Stall hold: at pc=8'h20 with IF/ID holding pc 1C, apply 3 cycles of stall. pc stays 20 and IF/ID stays 1C/valid for all 3 cycles; fetch resumes to 24 afterwards.
- Memory not ready: imem_ready=0 for 2 cycles at pc=8'h30. pc stays 30 and two bubbles enter IF/ID; when ready returns, IF/ID gets 30 and pc becomes 34.
- Reset mid-run at pc=8'h58 with valid IF/ID: next cycle pc=RESET_PC, if_id_valid=0, state BOOT. With PERF_COUNTERS_EN defined, both counters read 0.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, imem address/request and IF/ID capture; fetch-to-IF/ID latency 1 cycle.
// Stall holds PC and IF/ID; a branch or imem not ready inserts a bubble. Optional counters under PERF_COUNTERS_EN.
module pc_fetch_stage #(
   parameter int                PC_W        = 8,
   parameter int                INSTR_W     = 32,
   parameter logic [PC_W-1:0]   RESET_PC    = '0,
   parameter int                PC_STEP     = 4,
   parameter int                BOOT_CYCLES = 2,
   parameter logic [INSTR_W-1:0] NOP_INSTR  = 32'h00000013
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_req,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W-1:0]    if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic               if_id_valid
`ifdef PERF_COUNTERS_EN
   ,
   output logic [15:0]        perf_fetch_cnt,
   output logic [15:0]        perf_bubble_cnt
`endif
);

   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int          CNT_W      = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
   localparam logic [0:0]  INIT_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BOOT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PC_W-1:0]  PC_INC   = PC_W'(PC_STEP);
   // PC_STEP is a power of two, so PC_STEP-1 is exactly the low alignment bits.
   localparam logic [PC_W-1:0]  ALIGN_MASK = ~(PC_W'(PC_STEP - 1));

   logic [0:0]         state_q, state_d;
   logic [CNT_W-1:0]   boot_cnt_q, boot_cnt_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    if_id_pc_q, if_id_pc_d;
   logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
   logic               if_id_valid_q, if_id_valid_d;
   logic               fetch_evt;
   logic               bubble_evt;

   always_comb begin
      state_d       = state_q;
      boot_cnt_d    = boot_cnt_q;
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      fetch_evt     = 1'b0;
      bubble_evt    = 1'b0;

      if (state_q == ST_BOOT) begin
         pc_d          = RESET_PC;
         if_id_pc_d    = '0;
         if_id_instr_d = NOP_INSTR;
         if_id_valid_d = 1'b0;
         boot_cnt_d    = boot_cnt_q - CNT_ONE;
         if (boot_cnt_q <= CNT_ONE) begin
            state_d = ST_RUN;
         end
      end else if (branch_taken) begin
         pc_d          = branch_target & ALIGN_MASK;
         if_id_pc_d    = '0;
         if_id_instr_d = NOP_INSTR;
         if_id_valid_d = 1'b0;
         bubble_evt    = 1'b1;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (!imem_ready) begin
         if_id_pc_d    = '0;
         if_id_instr_d = NOP_INSTR;
         if_id_valid_d = 1'b0;
         bubble_evt    = 1'b1;
      end else begin
         if_id_pc_d    = pc_q;
         if_id_instr_d = imem_data;
         if_id_valid_d = 1'b1;
         pc_d          = pc_q + PC_INC;
         fetch_evt     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= INIT_STATE;
         boot_cnt_q    <= CNT_INIT;
         pc_q          <= RESET_PC;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_INSTR;
         if_id_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         boot_cnt_q    <= boot_cnt_d;
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

`ifdef PERF_COUNTERS_EN
   logic [15:0] perf_fetch_q, perf_fetch_d;
   logic [15:0] perf_bubble_q, perf_bubble_d;

   always_comb begin
      perf_fetch_d  = perf_fetch_q;
      perf_bubble_d = perf_bubble_q;
      if (fetch_evt && perf_fetch_q != 16'hFFFF) begin
         perf_fetch_d = perf_fetch_q + 16'd1;
      end
      if (bubble_evt && perf_bubble_q != 16'hFFFF) begin
         perf_bubble_d = perf_bubble_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q  <= '0;
         perf_bubble_q <= '0;
      end else begin
         perf_fetch_q  <= perf_fetch_d;
         perf_bubble_q <= perf_bubble_d;
      end
   end

   assign perf_fetch_cnt  = perf_fetch_q;
   assign perf_bubble_cnt = perf_bubble_q;
`else
   logic unused_evt;
   assign unused_evt = fetch_evt ^ bubble_evt;
`endif

   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign imem_req    = (state_q == ST_RUN);
   assign if_id_pc    = if_id_pc_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: boot delay, wrap, branch/stall priority, stall hold, imem not ready, mid-run reset.
module tb_pc_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic        imem_ready;
   logic [31:0] imem_data;
   logic [7:0]  imem_addr;
   logic        imem_req;
   logic [7:0]  pc;
   logic [7:0]  if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
`ifdef PERF_COUNTERS_EN
   logic [15:0] perf_fetch_cnt;
   logic [15:0] perf_bubble_cnt;
`endif

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   // Memory returns a word tagged with its own address.
   assign imem_data = {24'hC0DE00, imem_addr};

   pc_fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_ready    (imem_ready),
      .imem_data     (imem_data),
      .imem_addr     (imem_addr),
      .imem_req      (imem_req),
      .pc            (pc),
      .if_id_pc      (if_id_pc),
      .if_id_instr   (if_id_instr),
      .if_id_valid   (if_id_valid)
`ifdef PERF_COUNTERS_EN
      ,
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [7:0] epc, input logic [31:0] einstr,
                           input logic evld);
      check({tag, ".if_id_pc"}, 32'(if_id_pc), 32'(epc));
      check({tag, ".if_id_instr"}, if_id_instr, einstr);
      check({tag, ".if_id_valid"}, 32'(if_id_valid), 32'(evld));
   endtask

   task automatic redirect(input logic [7:0] tgt);
      branch_taken  = 1'b1;
      branch_target = tgt;
      step();
      branch_taken  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; imem_ready = 1'b1;
      #2;
      step();
      check("rst.pc", 32'(pc), 32'h00);
      check("rst.imem_addr", 32'(imem_addr), 32'h00);
      check("rst.imem_req", 32'(imem_req), 32'h0);
      chk_ifid("rst", 8'h00, 32'h00000013, 1'b0);

      // Boot: first cycle also tries a branch, which must be ignored.
      rst = 1'b0; branch_taken = 1'b1; branch_target = 8'h80; stall = 1'b1;
      step();
      branch_taken = 1'b0; stall = 1'b0;
      check("boot1.pc", 32'(pc), 32'h00);
      check("boot1.imem_req", 32'(imem_req), 32'h0);
      check("boot1.valid", 32'(if_id_valid), 32'h0);
      step();
      check("boot2.pc", 32'(pc), 32'h00);
      check("boot2.valid", 32'(if_id_valid), 32'h0);
      check("boot2.imem_req", 32'(imem_req), 32'h1);
      step();
      check("run1.pc", 32'(pc), 32'h04);
      chk_ifid("run1", 8'h00, 32'hC0DE0000, 1'b1);
      step();
      check("run2.pc", 32'(pc), 32'h08);
      chk_ifid("run2", 8'h04, 32'hC0DE0004, 1'b1);

      // Wrap around the top of the address space.
      redirect(8'hF8);
      check("wrap0.pc", 32'(pc), 32'hF8);
      chk_ifid("wrap0", 8'h00, 32'h00000013, 1'b0);
      step();
      check("wrap1.pc", 32'(pc), 32'hFC);
      chk_ifid("wrap1", 8'hF8, 32'hC0DE00F8, 1'b1);
      step();
      check("wrap2.pc", 32'(pc), 32'h00);
      chk_ifid("wrap2", 8'hFC, 32'hC0DE00FC, 1'b1);
      step();
      check("wrap3.pc", 32'(pc), 32'h04);
      check("wrap3.if_id_pc", 32'(if_id_pc), 32'h00);

      // Branch beats stall; target low bits are cleared.
      redirect(8'h10);
      check("bstall0.pc", 32'(pc), 32'h10);
      stall = 1'b1; imem_ready = 1'b0;
      redirect(8'h43);
      stall = 1'b0; imem_ready = 1'b1;
      check("bstall.pc", 32'(pc), 32'h40);
      chk_ifid("bstall", 8'h00, 32'h00000013, 1'b0);

      // Stall holds PC and IF/ID for three cycles.
      redirect(8'h1C);
      step();
      check("sh0.pc", 32'(pc), 32'h20);
      chk_ifid("sh0", 8'h1C, 32'hC0DE001C, 1'b1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("sh%0d.pc", i + 1), 32'(pc), 32'h20);
         chk_ifid($sformatf("sh%0d", i + 1), 8'h1C, 32'hC0DE001C, 1'b1);
      end
      stall = 1'b0;
      step();
      check("sh_end.pc", 32'(pc), 32'h24);
      chk_ifid("sh_end", 8'h20, 32'hC0DE0020, 1'b1);

      // Memory not ready for two cycles.
      redirect(8'h30);
      imem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check($sformatf("nr%0d.pc", i), 32'(pc), 32'h30);
         chk_ifid($sformatf("nr%0d", i), 8'h00, 32'h00000013, 1'b0);
      end
      imem_ready = 1'b1;
      step();
      check("nr_end.pc", 32'(pc), 32'h34);
      chk_ifid("nr_end", 8'h30, 32'hC0DE0030, 1'b1);

      // Reset mid-run, with branch and stall also asserted.
      redirect(8'h54);
      step();
      check("mr0.pc", 32'(pc), 32'h58);
      chk_ifid("mr0", 8'h54, 32'hC0DE0054, 1'b1);
      rst = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 8'hA0;
      step();
      rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      check("mr.pc", 32'(pc), 32'h00);
      check("mr.imem_req", 32'(imem_req), 32'h0);
      chk_ifid("mr", 8'h00, 32'h00000013, 1'b0);
`ifdef PERF_COUNTERS_EN
      check("mr.perf_fetch", 32'(perf_fetch_cnt), 32'h0);
      check("mr.perf_bubble", 32'(perf_bubble_cnt), 32'h0);
`endif
      step();
      check("mr_boot.pc", 32'(pc), 32'h00);
      check("mr_boot.imem_req", 32'(imem_req), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
